// File: rtl/mem_access_unit.sv
// Memory-stage access unit: turns MEM/size control into a byte-lane req/ack transaction and extends load data.
// Optional MEM_TIMEOUT_EN adds an ack timeout that aborts the request and pulses outBusError.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inValid,
    input  logic [1:0]            inMemCtrl,
    input  logic [2:0]            inSize,
    input  logic [ADDR_WIDTH-1:0] inAddress,
    input  logic [31:0]           inWriteData,
    output logic                  outStall,
    output logic                  outDone,
    output logic [31:0]           outReadData,
    output logic                  outMisaligned,
    output logic                  outBusError,
    output logic                  outMemReq,
    output logic                  outMemWe,
    output logic [ADDR_WIDTH-1:0] outMemAddr,
    output logic [3:0]            outMemByteEn,
    output logic [31:0]           outMemWData,
    input  logic                  inMemAck,
    input  logic [31:0]           inMemRData
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            lane_q, lane_d;
    logic [2:0]            size_q, size_d;
    logic                  we_q, we_d;
    logic [3:0]            be_q, be_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  misaligned_q, misaligned_d;

    logic        is_byte, is_half, access, misaligned;
    logic [3:0]  be_in;
    logic [31:0] wdata_in;

    // Size codes 011/100/111 fall through to word.
    assign is_byte    = (inSize[1:0] == 2'b01);
    assign is_half    = (inSize[1:0] == 2'b10);
    assign access     = inValid && (inMemCtrl != 2'b00);
    assign misaligned = (is_half && inAddress[0]) ||
                        (!is_byte && !is_half && (inAddress[1:0] != 2'b00));

    always_comb begin
        be_in    = 4'b1111;
        wdata_in = inWriteData;
        if (is_byte) begin
            be_in    = 4'b0001 << inAddress[1:0];
            wdata_in = {4{inWriteData[7:0]}};
        end else if (is_half) begin
            be_in    = inAddress[1] ? 4'b1100 : 4'b0011;
            wdata_in = {2{inWriteData[15:0]}};
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_q, cnt_d;
    logic       bus_error_q, bus_error_d;
`endif

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case infers a latch.
        state_d      = state_q;
        addr_d       = addr_q;
        lane_d       = lane_q;
        size_d       = size_q;
        we_d         = we_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        misaligned_d = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d        = cnt_q;
        bus_error_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    if (misaligned) begin
                        misaligned_d = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                        addr_d  = {inAddress[ADDR_WIDTH-1:2], 2'b00};
                        lane_d  = inAddress[1:0];
                        size_d  = inSize;
                        we_d    = (inMemCtrl == 2'b01);
                        be_d    = be_in;
                        wdata_d = wdata_in;
`ifdef MEM_TIMEOUT_EN
                        cnt_d   = 8'd0;
`endif
                    end
                end
            end
            ST_REQ: begin
                if (inMemAck) begin
                    rdata_d = inMemRData;
                    state_d = ST_RESP;
                end
`ifdef MEM_TIMEOUT_EN
                // An ack in the limit cycle takes priority over the abort.
                else if (cnt_q == TIMEOUT_LAST) begin
                    bus_error_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            lane_q       <= 2'b00;
            size_q       <= 3'b000;
            we_q         <= 1'b0;
            be_q         <= 4'b0000;
            wdata_q      <= 32'd0;
            rdata_q      <= 32'd0;
            misaligned_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q        <= 8'd0;
            bus_error_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            lane_q       <= lane_d;
            size_q       <= size_d;
            we_q         <= we_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            misaligned_q <= misaligned_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q        <= cnt_d;
            bus_error_q  <= bus_error_d;
`endif
        end
    end

`ifdef MEM_TIMEOUT_EN
    assign outBusError = bus_error_q;
`else
    assign outBusError = 1'b0;
`endif

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;

    always_comb begin
        byte_sel = rdata_q[8*lane_q +: 8];
        half_sel = lane_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (size_q[1:0])
            2'b01:   load_val = {{24{size_q[2] & byte_sel[7]}}, byte_sel};
            2'b10:   load_val = {{16{size_q[2] & half_sel[15]}}, half_sel};
            default: load_val = rdata_q;
        endcase
    end

    assign outStall      = (state_q == ST_REQ) ||
                           ((state_q == ST_IDLE) && access && !misaligned);
    assign outDone       = (state_q == ST_RESP);
    assign outReadData   = (state_q == ST_RESP && !we_q) ? load_val : 32'd0;
    assign outMisaligned = misaligned_q;
    assign outMemReq     = (state_q == ST_REQ);
    assign outMemWe      = we_q;
    assign outMemAddr    = addr_q;
    assign outMemByteEn  = be_q;
    assign outMemWData   = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized accesses against a byte-level model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid;
    logic [1:0]  inMemCtrl;
    logic [2:0]  inSize;
    logic [31:0] inAddress;
    logic [31:0] inWriteData;
    logic        outStall, outDone, outMisaligned, outBusError;
    logic [31:0] outReadData;
    logic        outMemReq, outMemWe;
    logic [31:0] outMemAddr;
    logic [3:0]  outMemByteEn;
    logic [31:0] outMemWData;
    logic        inMemAck;
    logic [31:0] inMemRData;

    int n_checks = 0;
    int n_pass   = 0;

    mem_access_unit #(.TIMEOUT_CYCLES(4), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .inValid(inValid), .inMemCtrl(inMemCtrl), .inSize(inSize),
        .inAddress(inAddress), .inWriteData(inWriteData), .outStall(outStall), .outDone(outDone),
        .outReadData(outReadData), .outMisaligned(outMisaligned), .outBusError(outBusError),
        .outMemReq(outMemReq), .outMemWe(outMemWe), .outMemAddr(outMemAddr),
        .outMemByteEn(outMemByteEn), .outMemWData(outMemWData), .inMemAck(inMemAck),
        .inMemRData(inMemRData)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: access width in bytes, lanes and data computed arithmetically.
    function automatic int nbytes(input logic [2:0] s);
        case (s)
            3'b001, 3'b101: return 1;
            3'b010, 3'b110: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] s, input logic [31:0] a);
        int v;
        v = ((1 << nbytes(s)) - 1) << (a % 4);
        return 4'(v);
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] s, input logic [31:0] d);
        logic [31:0] r;
        int n;
        n = nbytes(s);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [2:0] s, input logic [31:0] a,
                                              input logic [31:0] mem);
        longint v;
        longint m;
        int n;
        n = nbytes(s);
        m = longint'({32'd0, mem});
        v = (m >> (8 * (a % 4))) & ((longint'(1) << (8 * n)) - 1);
        if ((s == 3'b101 || s == 3'b110) && v >= (longint'(1) << (8 * n - 1)))
            v = v + (longint'(1) << 32) - (longint'(1) << (8 * n));
        return 32'(v);
    endfunction

    // Called at a negedge; presents one access and plays the memory with a given ack delay.
    task automatic do_access(input string tag, input logic [1:0] ctrl, input logic [2:0] size,
                             input logic [31:0] addr, input logic [31:0] d,
                             input logic [31:0] mem, input int delay);
        bit is_store;
        bit mis;
        is_store = (ctrl == 2'b01);
        mis      = (addr % nbytes(size)) != 0;
        inValid = 1'b1; inMemCtrl = ctrl; inSize = size; inAddress = addr; inWriteData = d;
        #1;
        check({tag, " stall_present"}, outStall, !mis);
        @(negedge clk);
        if (mis) begin
            inValid = 1'b0;
            check({tag, " misaligned_pulse"}, outMisaligned, 1);
            check({tag, " no_req_mis"}, outMemReq, 0);
            @(negedge clk);
            check({tag, " misaligned_clear"}, outMisaligned, 0);
            check({tag, " no_req_after"}, outMemReq, 0);
            return;
        end
        check({tag, " req"}, outMemReq, 1);
        check({tag, " we"}, outMemWe, is_store);
        check({tag, " addr"}, outMemAddr, addr & 32'hFFFF_FFFC);
        check({tag, " byte_en"}, outMemByteEn, exp_be(size, addr));
        if (is_store) check({tag, " wdata"}, outMemWData, exp_wdata(size, d));
        check({tag, " stall_req"}, outStall, 1);
        repeat (delay) begin
            @(negedge clk);
            check({tag, " req_wait"}, outMemReq, 1);
            check({tag, " no_early_done"}, outDone, 0);
        end
        inMemAck = 1'b1;
        inMemRData = is_store ? $urandom : mem;
        @(negedge clk);
        inMemAck = 1'b0;
        check({tag, " done"}, outDone, 1);
        check({tag, " rdata"}, outReadData, is_store ? 32'd0 : exp_rdata(size, addr, mem));
        check({tag, " stall_resp"}, outStall, 0);
        check({tag, " req_dropped"}, outMemReq, 0);
        check({tag, " no_bus_error"}, outBusError, 0);
        inValid = 1'b0;
        @(negedge clk);
        check({tag, " done_one_cycle"}, outDone, 0);
    endtask

    initial begin
        int req_cnt;
        int done_cnt;
        int err_cycle;
        rst = 1'b1; inValid = 1'b0; inMemCtrl = 2'b00; inSize = 3'b000; inAddress = 32'd0;
        inWriteData = 32'd0; inMemAck = 1'b0; inMemRData = 32'd0;
        repeat (2) @(negedge clk);
        check("reset stall", outStall, 0);
        check("reset done", outDone, 0);
        check("reset rdata", outReadData, 0);
        check("reset req", outMemReq, 0);
        check("reset we", outMemWe, 0);
        check("reset addr", outMemAddr, 0);
        check("reset be", outMemByteEn, 0);
        check("reset wdata", outMemWData, 0);
        check("reset mis", outMisaligned, 0);
        check("reset buserr", outBusError, 0);
        rst = 1'b0;
        @(negedge clk);

        do_access("lb_signed", 2'b10, 3'b101, 32'h1003, 32'd0, 32'h80FF_1234, 2);
        do_access("lhu", 2'b10, 3'b010, 32'h2002, 32'd0, 32'hBEEF_0001, 0);
        do_access("sb", 2'b01, 3'b001, 32'h0001, 32'h1234_56AB, 32'd0, 1);
        do_access("mis_word", 2'b10, 3'b000, 32'h0006, 32'd0, 32'd0, 0);
        do_access("mis_half", 2'b01, 3'b110, 32'h0003, 32'h55AA, 32'd0, 0);
        do_access("ctrl11_load", 2'b11, 3'b110, 32'h0102, 32'd0, 32'h8001_7FFF, 3);
        do_access("size111_word", 2'b10, 3'b111, 32'h0010, 32'd0, 32'hCAFE_F00D, 0);
        do_access("sh_hi", 2'b01, 3'b010, 32'h0022, 32'h0000_9A5C, 32'd0, 0);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  ctrl;
            logic [2:0]  size;
            logic [31:0] addr;
            ctrl = 2'($urandom_range(1, 3));
            size = 3'($urandom);
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr = addr & ~32'(nbytes(size) - 1);
            do_access($sformatf("rand%0d", i), ctrl, size, addr, $urandom, $urandom,
                      $urandom_range(0, 3));
        end

        // Reset while a request is outstanding; the late ack must be ignored.
        inValid = 1'b1; inMemCtrl = 2'b10; inSize = 3'b000; inAddress = 32'h40;
        @(negedge clk);
        check("rst_mid req_before", outMemReq, 1);
        rst = 1'b1; inValid = 1'b0;
        @(negedge clk);
        check("rst_mid req_dropped", outMemReq, 0);
        rst = 1'b0; inMemAck = 1'b1; inMemRData = 32'h1111_2222;
        @(negedge clk);
        inMemAck = 1'b0;
        check("rst_mid no_done", outDone, 0);
        check("rst_mid idle_req", outMemReq, 0);
        check("rst_mid idle_stall", outStall, 0);
        @(negedge clk);
        check("rst_mid still_no_done", outDone, 0);

        // Ack never given: bounded observation window.
        inValid = 1'b1; inMemCtrl = 2'b10; inSize = 3'b000; inAddress = 32'h80;
        req_cnt = 0; done_cnt = 0; err_cycle = -1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            inValid = 1'b0;
            if (outMemReq) req_cnt++;
            if (outDone) done_cnt++;
            if (outBusError && err_cycle < 0) err_cycle = c;
        end
`ifdef MEM_TIMEOUT_EN
        check("timeout req_cycles", req_cnt, 4);
        check("timeout err_cycle", err_cycle, 5);
        check("timeout no_done", done_cnt, 0);
        check("timeout idle_stall", outStall, 0);
`else
        check("noack req_held", req_cnt, 12);
        check("noack no_err", err_cycle, -1);
        check("noack no_done", done_cnt, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("noack reset_clears", outMemReq, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
